// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared encodings for the execute stage: main-control ALUOp
//               values, 4-bit ALU control codes and R-type funct constants.
// Revision    : 1.0  initial release
// ============================================================================
package alu_pkg;

    localparam int DATA_W = 32;

    // Main-control ALUOp encodings
    localparam logic [1:0] ALUOP_MEM   = 2'b00;
    localparam logic [1:0] ALUOP_BR    = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_IMM   = 2'b11;

    // ALU control codes
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;
    localparam logic [3:0] ALU_INV = 4'b1111;

    // R-type funct field values
    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_NOR = 6'b100111;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_ctrl_decode.sv
`default_nettype none
// ============================================================================
// Module      : alu_ctrl_decode
// Description : Pure combinational ALUOp/funct -> 4-bit ALU control map.
//               Non-R-type opcodes ignore funct; unknown R-type funct values
//               map to the INVALID code.
// Ports       : alu_op   (in,  2) main-control ALUOp
//               funct    (in,  6) instruction[5:0]
//               alu_ctrl (out, 4) decoded ALU control code
// Revision    : 1.0  initial release
// ============================================================================
module alu_ctrl_decode
    import alu_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [5:0] funct,
    output logic [3:0] alu_ctrl
);

    always_comb begin
        alu_ctrl = ALU_INV;
        unique case (alu_op)
            ALUOP_MEM:   alu_ctrl = ALU_ADD;
            ALUOP_BR:    alu_ctrl = ALU_SUB;
            ALUOP_IMM:   alu_ctrl = ALU_ADD;
            ALUOP_RTYPE: begin
                case (funct)
                    FUNCT_ADD: alu_ctrl = ALU_ADD;
                    FUNCT_SUB: alu_ctrl = ALU_SUB;
                    FUNCT_AND: alu_ctrl = ALU_AND;
                    FUNCT_OR:  alu_ctrl = ALU_OR;
                    FUNCT_NOR: alu_ctrl = ALU_NOR;
                    FUNCT_SLT: alu_ctrl = ALU_SLT;
                    default:   alu_ctrl = ALU_INV;
                endcase
            end
            default:     alu_ctrl = ALU_INV;
        endcase
    end

endmodule : alu_ctrl_decode
`default_nettype wire

// File: rtl/alu_exec_unit.sv
`default_nettype none
// ============================================================================
// Module      : alu_exec_unit
// Description : Execute stage of the single-cycle MIPS datapath. Decodes the
//               ALU control code, performs the 32-bit ALU operation and
//               drives zero, signed overflow and the branch-taken select.
//               Registered copies of result/zero/overflow are kept for trace.
// Ports       : clk        (in,  1)  rising-edge clock
//               rst        (in,  1)  asynchronous active-low reset
//               alu_op     (in,  2)  main-control ALUOp
//               funct      (in,  6)  instruction[5:0]
//               branch     (in,  1)  Branch from main control
//               a, b       (in,  32) operands
//               alu_ctrl   (out, 4)  decoded ALU control code
//               result     (out, 32) ALU result (combinational)
//               zero       (out, 1)  result == 0 (combinational)
//               overflow   (out, 1)  signed ADD/SUB overflow (combinational)
//               pc_src     (out, 1)  branch & zero
//               result_q, zero_q, overflow_q (out) registered copies
// Revision    : 1.0  initial release
// ============================================================================
module alu_exec_unit
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        alu_op,
    input  logic [5:0]        funct,
    input  logic              branch,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [3:0]        alu_ctrl,
    output logic [DATA_W-1:0] result,
    output logic              zero,
    output logic              overflow,
    output logic              pc_src,
    output logic [DATA_W-1:0] result_q,
    output logic              zero_q,
    output logic              overflow_q
);

    logic [3:0]        dec_ctrl;
    logic [DATA_W-1:0] sum;
    logic [DATA_W-1:0] diff;
    logic [DATA_W-1:0] alu_res;
    logic              alu_ovf;
    logic              slt_bit;

    alu_ctrl_decode u_alu_ctrl_decode (
        .alu_op   (alu_op),
        .funct    (funct),
        .alu_ctrl (dec_ctrl)
    );

    assign sum  = a + b;
    assign diff = a - b;

    // Signed compare directly rather than the sign of a-b, so the answer
    // stays right when the subtraction overflows.
    assign slt_bit = ($signed(a) < $signed(b));

    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        case (dec_ctrl)
            ALU_AND: alu_res = a & b;
            ALU_OR:  alu_res = a | b;
            ALU_NOR: alu_res = ~(a | b);
            ALU_ADD: begin
                alu_res = sum;
                alu_ovf = (a[DATA_W-1] == b[DATA_W-1]) &&
                          (sum[DATA_W-1] != a[DATA_W-1]);
            end
            ALU_SUB: begin
                alu_res = diff;
                alu_ovf = (a[DATA_W-1] != b[DATA_W-1]) &&
                          (diff[DATA_W-1] != a[DATA_W-1]);
            end
            ALU_SLT: alu_res = {{(DATA_W-1){1'b0}}, slt_bit};
            default: alu_res = '0;
        endcase
    end

    // All combinational outputs are held at zero while reset is asserted.
    assign alu_ctrl = rst ? dec_ctrl : 4'b0000;
    assign result   = rst ? alu_res  : '0;
    assign zero     = rst & (alu_res == '0);
    assign overflow = rst & alu_ovf;
    assign pc_src   = branch & zero;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            result_q   <= '0;
            zero_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            result_q   <= result;
            zero_q     <= zero;
            overflow_q <= overflow;
        end
    end

endmodule : alu_exec_unit
`default_nettype wire

// File: tb/tb_alu_exec_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_exec_unit
// Description : Self-checking bench for alu_exec_unit: directed cases plus a
//               randomized run checked against a behavioural model built on
//               wide signed integer arithmetic.
// Revision    : 1.0  initial release
// ============================================================================
module tb_alu_exec_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  alu_op = 2'b00;
    logic [5:0]  funct = 6'd0;
    logic        branch = 1'b0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic [3:0]  alu_ctrl;
    logic [31:0] result;
    logic        zero;
    logic        overflow;
    logic        pc_src;
    logic [31:0] result_q;
    logic        zero_q;
    logic        overflow_q;

    int passed = 0;
    int total  = 0;

    alu_exec_unit dut (
        .clk        (clk),
        .rst        (rst),
        .alu_op     (alu_op),
        .funct      (funct),
        .branch     (branch),
        .a          (a),
        .b          (b),
        .alu_ctrl   (alu_ctrl),
        .result     (result),
        .zero       (zero),
        .overflow   (overflow),
        .pc_src     (pc_src),
        .result_q   (result_q),
        .zero_q     (zero_q),
        .overflow_q (overflow_q)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish (passed %0d of %0d)", passed, total);
        $fatal(1, "watchdog");
    end

    // Reference model: operation chosen from the opcode/funct table, values
    // computed as 64-bit signed integers and overflow judged by range.
    function automatic void model(input logic [1:0] op, input logic [5:0] fn,
                                  input logic br, input logic [31:0] x, input logic [31:0] y,
                                  output logic [3:0] ctl, output logic [31:0] res,
                                  output logic z, output logic ov, output logic pc);
        longint sx, sy, r;
        int     kind; // 0 add,1 sub,2 and,3 or,4 nor,5 slt,6 invalid
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        r  = 0;
        if (op == 2'b00 || op == 2'b11) kind = 0;
        else if (op == 2'b01)           kind = 1;
        else begin
            case (fn)
                6'h20:   kind = 0;
                6'h22:   kind = 1;
                6'h24:   kind = 2;
                6'h25:   kind = 3;
                6'h27:   kind = 4;
                6'h2A:   kind = 5;
                default: kind = 6;
            endcase
        end
        ov = 1'b0;
        case (kind)
            0: begin ctl = 4'b0010; r = sx + sy; res = r[31:0];
                     ov = (r > 64'sd2147483647) || (r < -64'sd2147483648); end
            1: begin ctl = 4'b0110; r = sx - sy; res = r[31:0];
                     ov = (r > 64'sd2147483647) || (r < -64'sd2147483648); end
            2: begin ctl = 4'b0000; res = x & y; end
            3: begin ctl = 4'b0001; res = x | y; end
            4: begin ctl = 4'b1100; res = ~(x | y); end
            5: begin ctl = 4'b0111; res = (sx < sy) ? 32'd1 : 32'd0; end
            default: begin ctl = 4'b1111; res = 32'd0; end
        endcase
        z  = (res == 32'd0);
        pc = br & z;
    endfunction

    task automatic set_in(input logic [1:0] op, input logic [5:0] fn, input logic br,
                          input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        alu_op = op; funct = fn; branch = br; a = x; b = y;
        #1;
    endtask

    task automatic test_reset();
        set_in(2'b10, 6'b100000, 1'b1, 32'd5, 32'd3);
        repeat (2) @(negedge clk);
        #1;
        total++; if ({alu_ctrl, result, zero, overflow, pc_src} !== 39'd0)
            $display("FAIL reset_comb: ctrl=%b result=%h zero=%b ovf=%b pc_src=%b, need all 0",
                     alu_ctrl, result, zero, overflow, pc_src);
        else passed++;
        total++; if ({result_q, zero_q, overflow_q} !== 34'd0)
            $display("FAIL reset_regs: result_q=%h zero_q=%b ovf_q=%b, need 0", result_q, zero_q, overflow_q);
        else passed++;
        @(negedge clk);
        rst = 1'b1;
        #1;
        total++; if (result !== 32'd8 || alu_ctrl !== 4'b0010)
            $display("FAIL reset_release: result=%h ctrl=%b, need 00000008/0010", result, alu_ctrl);
        else passed++;
        total++; if (result_q !== 32'd0)
            $display("FAIL reset_release_q: result_q=%h before edge, need 0", result_q);
        else passed++;
        @(negedge clk);
        total++; if (result_q !== 32'd8 || zero_q !== 1'b0)
            $display("FAIL first_capture: result_q=%h zero_q=%b, need 00000008/0", result_q, zero_q);
        else passed++;
    endtask

    task automatic test_decode();
        logic [1:0] ops[3]  = '{2'b00, 2'b01, 2'b11};
        logic [3:0] opc[3]  = '{4'b0010, 4'b0110, 4'b0010};
        logic [5:0] fns[7]  = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100111, 6'b101010, 6'b000000};
        logic [3:0] fnc[7]  = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b1100, 4'b0111, 4'b1111};
        for (int i = 0; i < 3; i++) begin
            set_in(ops[i], 6'($urandom), 1'b0, $urandom, $urandom);
            total++; if (alu_ctrl !== opc[i])
                $display("FAIL decode_op%b: alu_ctrl=%b, need %b", ops[i], alu_ctrl, opc[i]);
            else passed++;
        end
        for (int i = 0; i < 7; i++) begin
            set_in(2'b10, fns[i], 1'b0, 32'h0000_1234, 32'h0000_0F0F);
            total++; if (alu_ctrl !== fnc[i])
                $display("FAIL decode_funct%b: alu_ctrl=%b, need %b", fns[i], alu_ctrl, fnc[i]);
            else passed++;
        end
        total++; if (result !== 32'd0 || zero !== 1'b1)
            $display("FAIL invalid_funct: result=%h zero=%b, need 0/1", result, zero);
        else passed++;
    endtask

    task automatic test_arith();
        logic [1:0]  op[3] = '{2'b10, 2'b10, 2'b00};
        logic [5:0]  fn[3] = '{6'b100000, 6'b100010, 6'b000000};
        logic [31:0] xa[3] = '{32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};
        logic [31:0] xb[3] = '{32'h0000_0001, 32'h0000_0001, 32'h0000_0001};
        logic [31:0] er[3] = '{32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0000};
        logic        ez[3] = '{1'b0, 1'b0, 1'b1};
        logic        eo[3] = '{1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 3; i++) begin
            set_in(op[i], fn[i], 1'b0, xa[i], xb[i]);
            total++; if (result !== er[i] || zero !== ez[i] || overflow !== eo[i])
                $display("FAIL arith_%0d: result=%h zero=%b ovf=%b, need %h/%b/%b",
                         i, result, zero, overflow, er[i], ez[i], eo[i]);
            else passed++;
        end
    endtask

    task automatic test_logic();
        logic [5:0]  fn[3] = '{6'b100100, 6'b100101, 6'b100111};
        logic [31:0] er[3] = '{32'h00F0_00F0, 32'hFFF0_FFF0, 32'h000F_000F};
        for (int i = 0; i < 3; i++) begin
            set_in(2'b10, fn[i], 1'b0, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
            total++; if (result !== er[i] || overflow !== 1'b0)
                $display("FAIL logic_%b: result=%h ovf=%b, need %h/0", fn[i], result, overflow, er[i]);
            else passed++;
        end
    endtask

    task automatic test_slt();
        logic [31:0] xa[3] = '{32'hFFFF_FFFF, 32'h0000_0001, 32'h8000_0000};
        logic [31:0] xb[3] = '{32'h0000_0001, 32'hFFFF_FFFF, 32'h7FFF_FFFF};
        logic [31:0] er[3] = '{32'd1, 32'd0, 32'd1};
        for (int i = 0; i < 3; i++) begin
            set_in(2'b10, 6'b101010, 1'b0, xa[i], xb[i]);
            total++; if (result !== er[i])
                $display("FAIL slt_%0d: result=%h, need %h", i, result, er[i]);
            else passed++;
        end
    endtask

    task automatic test_branch();
        set_in(2'b01, 6'd0, 1'b1, 32'h1234, 32'h1234);
        total++; if (zero !== 1'b1 || pc_src !== 1'b1)
            $display("FAIL branch_taken: zero=%b pc_src=%b, need 1/1", zero, pc_src);
        else passed++;
        set_in(2'b01, 6'd0, 1'b1, 32'h1234, 32'h1235);
        total++; if (zero !== 1'b0 || pc_src !== 1'b0)
            $display("FAIL branch_not_taken: zero=%b pc_src=%b, need 0/0", zero, pc_src);
        else passed++;
        set_in(2'b01, 6'd0, 1'b0, 32'h1234, 32'h1234);
        total++; if (zero !== 1'b1 || pc_src !== 1'b0)
            $display("FAIL branch_off: zero=%b pc_src=%b, need 1/0", zero, pc_src);
        else passed++;
    endtask

    // Random back-to-back traffic: combinational outputs checked each cycle,
    // registered outputs checked against the previous cycle's model values.
    task automatic test_back_to_back();
        logic [5:0]  legal[6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A};
        logic [31:0] corner[5] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
        logic [1:0]  op; logic [5:0] fn; logic br; logic [31:0] x, y;
        logic [3:0]  ectl; logic [31:0] eres; logic ez, eov, epc;
        logic [31:0] pres; logic pz, pov;
        model(alu_op, funct, branch, a, b, ectl, pres, pz, pov, epc);
        for (int n = 0; n < 300; n++) begin
            op = 2'($urandom_range(0, 3));
            fn = ($urandom_range(0, 7) == 0) ? 6'($urandom) : legal[$urandom_range(0, 5)];
            br = 1'($urandom);
            x  = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
            y  = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
            if ($urandom_range(0, 7) == 0) y = x;
            @(negedge clk);
            total++; if (result_q !== pres || zero_q !== pz || overflow_q !== pov)
                $display("FAIL b2b_regs_%0d: result_q=%h zero_q=%b ovf_q=%b, need %h/%b/%b",
                         n, result_q, zero_q, overflow_q, pres, pz, pov);
            else passed++;
            alu_op = op; funct = fn; branch = br; a = x; b = y;
            #1;
            model(op, fn, br, x, y, ectl, eres, ez, eov, epc);
            total++; if (alu_ctrl !== ectl || result !== eres || zero !== ez ||
                         overflow !== eov || pc_src !== epc)
                $display("FAIL b2b_comb_%0d: op=%b fn=%b a=%h b=%h got ctrl=%b res=%h z=%b ov=%b pc=%b need %b/%h/%b/%b/%b",
                         n, op, fn, x, y, alu_ctrl, result, zero, overflow, pc_src,
                         ectl, eres, ez, eov, epc);
            else passed++;
            pres = eres; pz = ez; pov = eov;
        end
    endtask

    // Reset asserted between edges must clear the registers at once.
    task automatic test_async_reset();
        set_in(2'b10, 6'b100000, 1'b0, 32'h7FFF_FFFF, 32'h1);
        @(negedge clk);
        total++; if (result_q !== 32'h8000_0000 || overflow_q !== 1'b1)
            $display("FAIL async_preload: result_q=%h ovf_q=%b, need 80000000/1", result_q, overflow_q);
        else passed++;
        #2 rst = 1'b0;
        #1;
        total++; if (result_q !== 32'd0 || overflow_q !== 1'b0 || zero_q !== 1'b0)
            $display("FAIL async_clear: result_q=%h ovf_q=%b zero_q=%b, need 0", result_q, overflow_q, zero_q);
        else passed++;
        @(negedge clk);
        total++; if (result_q !== 32'd0)
            $display("FAIL async_hold: result_q=%h while in reset, need 0", result_q);
        else passed++;
        rst = 1'b1;
        @(negedge clk);
        total++; if (result_q !== 32'h8000_0000 || overflow_q !== 1'b1)
            $display("FAIL async_recapture: result_q=%h ovf_q=%b, need 80000000/1", result_q, overflow_q);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_decode();
        test_arith();
        test_logic();
        test_slt();
        test_branch();
        test_back_to_back();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule : tb_alu_exec_unit
`default_nettype wire
